// File: rtl/dish_washer_pkg.sv
// Shared types and default constants for the dish washer plant model and its benches.
package dish_washer_pkg;

  // Wash-cycle phase tracked by the plant's timer FSM.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DOSE       = 3'd1,
    WASH       = 3'd2,
    WAIT_DRAIN = 3'd3,
    STORE      = 3'd4
  } phase_t;

  localparam int DEF_FULL_LEVEL   = 200;
  localparam int DEF_FILL_RATE    = 4;
  localparam int DEF_FILL_RATE_2  = 2;
  localparam int DEF_DRAIN_RATE   = 5;
  localparam int DEF_DET_CYCLES   = 8;
  localparam int DEF_WASH_CYCLES  = 64;
  localparam int DEF_STORE_CYCLES = 32;

  // Largest of three durations, used to size the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/dw_phase_timer.sv
// Phase timer: up-counter cleared on phase entry, flags the last cycle of a phase.
module dw_phase_timer #(
  parameter int W = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Count cycles spent in the current phase; clear restarts from zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + W'(1);
    end
  end

  // Terminal count: the phase ends on the edge following count == limit-1.
  assign o_tc = (r_count == (i_limit - W'(1)));

endmodule

// File: rtl/dish_washer_plant_model.sv
// Plant/sensor model opposite the dish washer controller: integrates tank level
// from valve commands and times the dose/wash/store phases.
module dish_washer_plant_model
  import dish_washer_pkg::*;
#(
  parameter int FULL_LEVEL   = DEF_FULL_LEVEL,
  parameter int FILL_RATE    = DEF_FILL_RATE,
  parameter int FILL_RATE_2  = DEF_FILL_RATE_2,
  parameter int DRAIN_RATE   = DEF_DRAIN_RATE,
  parameter int DET_CYCLES   = DEF_DET_CYCLES,
  parameter int WASH_CYCLES  = DEF_WASH_CYCLES,
  parameter int STORE_CYCLES = DEF_STORE_CYCLES
) (
  input  logic   Clock,
  input  logic   Reset,
  input  logic   Fill_valve_on,
  input  logic   Fill_valve_second_on,
  input  logic   Drained_valve_on,
  input  logic   Door_Lock,
  input  logic   Done,
  output logic   Filled,
  output logic   Drained,
  output logic   Detergent_Added,
  output logic   Washing_Timeout,
  output logic   Store_Timeout,
  output logic   Overflow,
  output phase_t o_phase
);

  localparam int LW = $clog2(FULL_LEVEL + 1);
  localparam int SW = LW + 2;
  localparam int TW = $clog2(max3(DET_CYCLES, WASH_CYCLES, STORE_CYCLES) + 1);

  logic [LW-1:0]        r_level;
  logic                 r_filled;
  logic                 r_drained;
  logic                 r_overflow;
  logic signed [SW-1:0] w_sum;
  logic [LW-1:0]        w_next_level;

  phase_t               r_state;
  phase_t               w_next_state;
  logic                 r_det;
  logic                 r_wash;
  logic                 r_store;
  logic                 w_det;
  logic                 w_wash;
  logic                 w_store;
  logic [TW-1:0]        w_limit;
  logic                 w_timer_clear;
  logic                 w_tc;

  // Net flow for this cycle, computed signed with guard bits and clamped to the tank.
  always_comb begin
    w_sum = $signed({2'b00, r_level});
    if (Fill_valve_on)        w_sum = w_sum + SW'(FILL_RATE);
    if (Fill_valve_second_on) w_sum = w_sum + SW'(FILL_RATE_2);
    if (Drained_valve_on)     w_sum = w_sum - SW'(DRAIN_RATE);
    if (w_sum[SW-1]) begin
      w_next_level = '0;
    end else if (w_sum > SW'(FULL_LEVEL)) begin
      w_next_level = LW'(FULL_LEVEL);
    end else begin
      w_next_level = w_sum[LW-1:0];
    end
  end

  // Level register, registered level sensors and the sticky overflow fault.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_level    <= '0;
      r_filled   <= 1'b0;
      r_drained  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_level   <= w_next_level;
      r_filled  <= (w_next_level == LW'(FULL_LEVEL));
      r_drained <= (w_next_level == '0) && Drained_valve_on;
      if ((r_level == LW'(FULL_LEVEL)) && (Fill_valve_on || Fill_valve_second_on)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Phase next-state and pulse decode; Done beats door abort, abort beats expiry.
  always_comb begin
    w_next_state = r_state;
    w_det        = 1'b0;
    w_wash       = 1'b0;
    w_store      = 1'b0;
    case (r_state)
      WASH:    w_limit = TW'(WASH_CYCLES);
      STORE:   w_limit = TW'(STORE_CYCLES);
      default: w_limit = TW'(DET_CYCLES);
    endcase
    if (Done) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_filled && Door_Lock) w_next_state = DOSE;
        end
        DOSE: begin
          if (!Door_Lock) begin
            w_next_state = IDLE;
          end else if (w_tc) begin
            w_next_state = WASH;
            w_det        = 1'b1;
          end
        end
        WASH: begin
          if (!Door_Lock) begin
            w_next_state = IDLE;
          end else if (w_tc) begin
            w_next_state = WAIT_DRAIN;
            w_wash       = 1'b1;
          end
        end
        WAIT_DRAIN: begin
          if (r_drained) w_next_state = STORE;
        end
        STORE: begin
          if (w_tc) begin
            w_next_state = IDLE;
            w_store      = 1'b1;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
    w_timer_clear = (w_next_state != r_state);
  end

  // Phase state and one-cycle completion pulses.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_det   <= 1'b0;
      r_wash  <= 1'b0;
      r_store <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_det   <= w_det;
      r_wash  <= w_wash;
      r_store <= w_store;
    end
  end

  dw_phase_timer #(.W(TW)) u_timer (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_clear (w_timer_clear),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  assign Filled          = r_filled;
  assign Drained         = r_drained;
  assign Detergent_Added = r_det;
  assign Washing_Timeout = r_wash;
  assign Store_Timeout   = r_store;
  assign Overflow        = r_overflow;
  assign o_phase         = r_state;

endmodule

// File: doc/dish_washer_plant_model.md
# dish_washer_plant_model

Behavioural plant/sensor model for the automatic dish washing machine controller. It consumes the controller's actuator outputs (valves, door lock, done) and produces the sensor and timer inputs the controller expects (Filled, Drained, Detergent_Added, Washing_Timeout, Store_Timeout). It sits opposite the controller in closed-loop benches, replacing hand-timed stimulus. It is synthesizable so it can also run in FPGA demo builds.

## Interface
- FULL_LEVEL, 200: water level at which Filled asserts; upper clamp for the level.
- FILL_RATE, 4: level units added per cycle while Fill_valve_on.
- FILL_RATE_2, 2: level units added per cycle while Fill_valve_second_on.
- DRAIN_RATE, 5: level units removed per cycle while Drained_valve_on.
- DET_CYCLES, 8: detergent dosing duration in cycles; must be ≥1.
- WASH_CYCLES, 64: wash duration in cycles; must be ≥1.
- STORE_CYCLES, 32: storage/dry duration in cycles; must be ≥1.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Fill_valve_on  in  1  main fill valve open.
- Fill_valve_second_on  in  1  secondary fill valve open.
- Drained_valve_on  in  1  drain valve open.
- Door_Lock  in  1  door locked by controller.
- Done  in  1  controller cycle complete.
- Filled  out  1  tank at FULL_LEVEL.
- Drained  out  1  tank empty while draining.
- Detergent_Added  out  1  one-cycle pulse, dosing finished.
- Washing_Timeout  out  1  one-cycle pulse, wash finished.
- Store_Timeout  out  1  one-cycle pulse, storage finished.
- Overflow  out  1  sticky fault: fill requested while full.

## Operation
- Level register, width clog2(FULL_LEVEL+1). Per cycle: next = level + inflow − outflow, where inflow = FILL_RATE·Fill_valve_on + FILL_RATE_2·Fill_valve_second_on and outflow = DRAIN_RATE·Drained_valve_on. Compute signed with 2 guard bits, then clamp to [0, FULL_LEVEL]. Simultaneous fill and drain apply the net value.
- Filled <= (next == FULL_LEVEL). Drained <= (next == 0) && Drained_valve_on.
- Overflow <= 1 when level == FULL_LEVEL and either fill valve is on. It clears only on Reset.
- Phase FSM states: IDLE, DOSE, WASH, WAIT_DRAIN, STORE.
  - IDLE→DOSE when Filled && Door_Lock.
  - DOSE→WASH after DET_CYCLES cycles; Detergent_Added pulses on the transition edge.
  - WASH→WAIT_DRAIN after WASH_CYCLES cycles; Washing_Timeout pulses on the transition edge.
  - WAIT_DRAIN→STORE when Drained == 1.
  - STORE→IDLE after STORE_CYCLES cycles; Store_Timeout pulses on the transition edge.
- Timer: loads 0 on phase entry and increments each cycle. When timer == N−1, the next edge asserts the pulse and changes state.
- Abort rules:
  - Door_Lock == 0 in DOSE or WASH returns the FSM to IDLE; no pulse.
  - Done == 1 returns the FSM to IDLE from any state; Done takes priority over abort and over timer expiry in the same cycle.
  - The level model is never affected by the FSM.

## Timing
- Reset: level = 0, state IDLE, timer 0, all outputs 0.
- Filled and Drained are registered: they assert on the edge where level reaches its bound.
- Pulse latency: Filled high at edge k → DOSE from edge k+1 → Detergent_Added high for the single cycle after edge k+1+DET_CYCLES. WASH and STORE follow the same pattern.
- Reset mid-phase clears state and level immediately (asynchronous); no pulse is emitted.

## Structure
- Package dish_washer_pkg: phase state enum and default rate/duration constants, shared with the controller bench.
- One sub-module, dw_phase_timer: up-counter with a clear input and a terminal-count pulse output. It is instantiated once and reloaded on each phase entry.

## Test plan
- Main valve only from reset → Filled rises at edge 50 (50×4 = 200); Overflow stays 0 once the valve closes.
- Both valves → Filled rises at edge 34 (clamped from 204 to 200). Holding the main valve one more cycle → Overflow = 1 and stays 1 until Reset.
- Full tank, then Door_Lock = 1 → Detergent_Added pulses 8 cycles after DOSE entry; Washing_Timeout pulses 64 cycles after WASH entry; each pulse is exactly 1 cycle wide.
- From WAIT_DRAIN with the drain valve open at level 200 → Drained rises after 40 cycles; Store_Timeout pulses 32 cycles after STORE entry; FSM returns to IDLE.
- Door_Lock drops at WASH cycle 20 → FSM returns to IDLE with no Washing_Timeout. Re-lock with the tank still full → DOSE restarts and the timer counts from 0.
- Done asserted in the same cycle as DOSE terminal count → no Detergent_Added pulse; next state is IDLE. Reset asserted mid-STORE → all outputs 0 asynchronously.
